// File: rtl/rx_ctrl_pkg.sv
// Shared constants and state encoding for the UART receive frame controller.
package rx_ctrl_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int DATA_W         = 8;

    // Bit positions inside the 10-bit frame delivered by the receiver
    localparam int START_BIT = 0;
    localparam int DATA_LSB  = 1;
    localparam int STOP_BIT  = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CHECK   = 3'd2,
        PUSH    = 3'd3,
        RECOVER = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_byte_fifo.sv
// Small synchronous byte FIFO; the head entry is presented directly from storage.
module rx_byte_fifo
    import rx_ctrl_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_rd_en,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [ADDR_W:0]     o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A write into a full FIFO is only allowed when a read frees the head slot in the same cycle
    assign w_rd = i_rd_en & ~o_empty;
    assign w_wr = i_wr_en & (~o_full | w_rd);

    // Storage, pointers (wrap naturally at DEPTH) and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: arms the UART receiver, checks frames, queues good bytes,
// and holds the receiver in reset after a framing error until the line is idle.
module rx_frame_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int ADDR_W       = 2,
    parameter int IDLE_SAMPLES = 8,
    parameter int CNT_W        = 8
) (
    input  logic                bclk_x8,
    input  logic                rst,
    input  logic                enable,
    input  logic                rx_line,
    input  logic [9:0]          frame_in,
    input  logic                frame_done,
    output logic                rx_hold,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W:0]     fifo_count,
    output logic                frame_err,
    output logic                overrun_err,
    output logic [CNT_W-1:0]    frame_err_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    input  logic                err_clear
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_ARMED   = ARMED;
    localparam logic [2:0] S_CHECK   = CHECK;
    localparam logic [2:0] S_PUSH    = PUSH;
    localparam logic [2:0] S_RECOVER = RECOVER;

    localparam int IDLE_W = $clog2(IDLE_SAMPLES + 1);

    logic [2:0]        r_state;
    logic [9:0]        r_frame;
    logic              r_fd_d;
    logic [IDLE_W-1:0] r_idle_cnt;

    logic w_fd_rise;
    logic w_frame_ok;
    logic w_bad;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_full;
    logic w_empty;

    assign w_fd_rise  = frame_done & ~r_fd_d;
    assign w_frame_ok = ~r_frame[START_BIT] & r_frame[STOP_BIT];
    // A frame abandoned by enable going low is neither checked nor pushed
    assign w_bad      = enable & (r_state == S_CHECK) & ~w_frame_ok;
    assign w_push     = enable & (r_state == S_PUSH);
    assign w_pop      = out_ready & ~w_empty;
    assign w_drop     = w_push & w_full & ~w_pop;

    assign rx_hold    = (r_state == S_IDLE) | (r_state == S_RECOVER);
    assign out_valid  = ~w_empty;

    rx_byte_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk     (bclk_x8),
        .i_rst     (rst),
        .i_wr_en   (w_push & ~w_drop),
        .i_wr_data (r_frame[DATA_LSB +: DATA_W]),
        .i_rd_en   (w_pop),
        .o_rd_data (out_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (fifo_count)
    );

    // Controller sequencing, frame capture and line-idle qualification
    always_ff @(posedge bclk_x8 or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_fd_d     <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_fd_d <= frame_done;
            if (!enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:  r_state <= S_ARMED;
                    S_ARMED: begin
                        if (w_fd_rise) begin
                            r_frame <= frame_in;
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (w_frame_ok) begin
                            r_state <= S_PUSH;
                        end else begin
                            r_idle_cnt <= '0;
                            r_state    <= S_RECOVER;
                        end
                    end
                    S_PUSH:  r_state <= S_ARMED;
                    S_RECOVER: begin
                        if (!rx_line) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == IDLE_W'(IDLE_SAMPLES - 1)) begin
                            r_idle_cnt <= '0;
                            r_state    <= S_ARMED;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky error flags and saturating counters; a new error outranks err_clear
    always_ff @(posedge bclk_x8 or posedge rst) begin
        if (rst) begin
            frame_err     <= 1'b0;
            frame_err_cnt <= '0;
            overrun_err   <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if (w_bad) begin
                frame_err     <= 1'b1;
                frame_err_cnt <= err_clear ? CNT_W'(1) :
                                 (&frame_err_cnt ? frame_err_cnt : frame_err_cnt + 1'b1);
            end else if (err_clear) begin
                frame_err     <= 1'b0;
                frame_err_cnt <= '0;
            end
            if (w_drop) begin
                overrun_err <= 1'b1;
                drop_cnt    <= err_clear ? CNT_W'(1) :
                               (&drop_cnt ? drop_cnt : drop_cnt + 1'b1);
            end else if (err_clear) begin
                overrun_err <= 1'b0;
                drop_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl.
module tb_rx_frame_ctrl;

    logic       bclk_x8 = 1'b0;
    logic       rst;
    logic       enable;
    logic       rx_line;
    logic [9:0] frame_in;
    logic       frame_done;
    logic       rx_hold;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun_err;
    logic [7:0] frame_err_cnt;
    logic [7:0] drop_cnt;
    logic       err_clear;

    int errors = 0;
    int checks = 0;

    rx_frame_ctrl #(
        .FIFO_DEPTH   (4),
        .ADDR_W       (2),
        .IDLE_SAMPLES (8),
        .CNT_W        (8)
    ) dut (
        .bclk_x8       (bclk_x8),
        .rst           (rst),
        .enable        (enable),
        .rx_line       (rx_line),
        .frame_in      (frame_in),
        .frame_done    (frame_done),
        .rx_hold       (rx_hold),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_count    (fifo_count),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .frame_err_cnt (frame_err_cnt),
        .drop_cnt      (drop_cnt),
        .err_clear     (err_clear)
    );

    always #5 bclk_x8 = ~bclk_x8;

    task automatic tick();
        @(posedge bclk_x8);
        #1;
    endtask

    function automatic logic [9:0] mk_frame(input logic [7:0] d, input logic stop_b);
        return {stop_b, d, 1'b0};
    endfunction

    // One-cycle frame_done; returns just after the sampling edge E0
    task automatic pulse_done(input logic [9:0] f);
        frame_in   = f;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // Complete good frame; returns just after E2
    task automatic send_good(input logic [7:0] d);
        pulse_done(mk_frame(d, 1'b1));
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; rx_line = 1'b1; frame_in = '0; frame_done = 1'b0;
        out_ready = 1'b0; err_clear = 1'b0;
        #12;
        checks++; if (rx_hold !== 1'b1) begin errors++; $display("FAIL reset_rx_hold: got %b expected 1", rx_hold); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if ({frame_err, overrun_err, frame_err_cnt, drop_cnt} !== 18'd0) begin errors++; $display("FAIL reset_errors: got %b %b %h %h expected all zero", frame_err, overrun_err, frame_err_cnt, drop_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (rx_hold !== 1'b1) begin errors++; $display("FAIL idle_disabled_hold: got %b expected 1", rx_hold); end
        enable = 1'b1;
        tick();
        checks++; if (rx_hold !== 1'b0) begin errors++; $display("FAIL armed_hold: got %b expected 0", rx_hold); end
    endtask

    task automatic test_good_frame();
        pulse_done(10'b1_10100101_0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_valid_e0: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_valid_e1: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid_e2: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected a5", out_data); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL good_count: got %0d expected 1", fifo_count); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL good_pop: got count %0d valid %b expected 0 0", fifo_count, out_valid); end
    endtask

    task automatic test_multi_cycle_done();
        frame_in   = mk_frame(8'h3C, 1'b1);
        frame_done = 1'b1;
        repeat (3) tick();
        frame_done = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL multi_done_count: got %0d expected 1", fifo_count); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL multi_done_data: got %h expected 3c", out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_bad_stop();
        rx_line = 1'b0;
        pulse_done(mk_frame(8'h5A, 1'b0));
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bad_err_early: got %b expected 0", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", frame_err); end
        checks++; if (frame_err_cnt !== 8'd1) begin errors++; $display("FAIL bad_err_cnt: got %0d expected 1", frame_err_cnt); end
        checks++; if (rx_hold !== 1'b1) begin errors++; $display("FAIL bad_hold: got %b expected 1", rx_hold); end
        rx_line = 1'b1;
        pulse_done(mk_frame(8'h77, 1'b1));
        repeat (6) tick();
        checks++; if (rx_hold !== 1'b1) begin errors++; $display("FAIL recover_7high: got %b expected 1", rx_hold); end
        rx_line = 1'b0; tick();
        checks++; if (rx_hold !== 1'b1) begin errors++; $display("FAIL recover_low: got %b expected 1", rx_hold); end
        rx_line = 1'b1;
        repeat (7) tick();
        checks++; if (rx_hold !== 1'b1) begin errors++; $display("FAIL recover_7of8: got %b expected 1", rx_hold); end
        tick();
        checks++; if (rx_hold !== 1'b0) begin errors++; $display("FAIL recover_8of8: got %b expected 0", rx_hold); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL recover_ignored_done: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d expected 4", fifo_count); end
        checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun_err); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovr_drop_cnt: got %0d expected 1", drop_cnt); end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            checks++; if (out_data !== exp_b || out_valid !== 1'b1) begin errors++; $display("FAIL ovr_drain%0d: got %h valid %b expected %h valid 1", i, out_data, out_valid, exp_b); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovr_drained: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q [4];
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
        for (int i = 0; i < 4; i++) send_good(8'h11 + 8'(i));
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count_pre: got %0d expected 4", fifo_count); end
        pulse_done(mk_frame(8'h15, 1'b1));
        tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pop_count: got %0d expected 4", fifo_count); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_pop_drop: got %0d expected 1", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== exp_q[i]) begin errors++; $display("FAIL full_pop_drain%0d: got %h expected %h", i, out_data, exp_q[i]); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_err_clear();
        rx_line = 1'b1;
        pulse_done(mk_frame(8'h42, 1'b0));
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        checks++; if (frame_err !== 1'b1 || frame_err_cnt !== 8'd1) begin errors++; $display("FAIL clear_collide: got flag %b cnt %0d expected 1 1", frame_err, frame_err_cnt); end
        checks++; if (overrun_err !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL clear_drop: got flag %b cnt %0d expected 0 0", overrun_err, drop_cnt); end
        repeat (8) tick();
        checks++; if (rx_hold !== 1'b0) begin errors++; $display("FAIL clear_rearm: got %b expected 0", rx_hold); end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        checks++; if (frame_err !== 1'b0 || frame_err_cnt !== 8'd0) begin errors++; $display("FAIL clear_plain: got flag %b cnt %0d expected 0 0", frame_err, frame_err_cnt); end
    endtask

    task automatic test_enable_drop();
        out_ready = 1'b0;
        send_good(8'h66);
        pulse_done(mk_frame(8'h77, 1'b1));
        enable = 1'b0;
        tick();
        checks++; if (rx_hold !== 1'b1) begin errors++; $display("FAIL en_drop_hold: got %b expected 1", rx_hold); end
        repeat (2) tick();
        checks++; if (fifo_count !== 3'd1 || out_data !== 8'h66) begin errors++; $display("FAIL en_drop_fifo: got count %0d data %h expected 1 66", fifo_count, out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL en_drop_drain: got %0d expected 0", fifo_count); end
        enable = 1'b1; tick();
        checks++; if (rx_hold !== 1'b0) begin errors++; $display("FAIL en_rearm: got %b expected 0", rx_hold); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_good(8'h99);
        rx_line = 1'b0;
        pulse_done(mk_frame(8'h24, 1'b0));
        tick();
        checks++; if (frame_err !== 1'b1 || fifo_count !== 3'd1) begin errors++; $display("FAIL arst_setup: got err %b count %0d expected 1 1", frame_err, fifo_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rx_hold !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_ctrl: got hold %b valid %b expected 1 0", rx_hold, out_valid); end
        checks++; if (out_data !== 8'h00 || fifo_count !== 3'd0) begin errors++; $display("FAIL arst_fifo: got data %h count %0d expected 00 0", out_data, fifo_count); end
        checks++; if ({frame_err, overrun_err, frame_err_cnt, drop_cnt} !== 18'd0) begin errors++; $display("FAIL arst_errors: got %b %b %h %h expected all zero", frame_err, overrun_err, frame_err_cnt, drop_cnt); end
        #2 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_multi_cycle_done();
        test_bad_stop();
        test_overrun();
        test_full_pop();
        test_err_clear();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Sequences the 8x-oversampled UART receiver and sits between it and the byte consumer.
- Captures each completed 10-bit frame and checks the start and stop bits.
- Pushes good data bytes into a small FIFO presented as a valid/ready stream.
- On framing errors, holds the receiver in reset until the line has been idle long enough, then re-arms it. Counts framing and overrun errors.

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2.
- ADDR_W, 2: log2(FIFO_DEPTH).
- IDLE_SAMPLES, 8: consecutive high rx_line samples needed to leave RECOVER.
- CNT_W, 8: width of the saturating error counters.

Ports:
- bclk_x8  in  1  8x-baud clock shared with the receiver.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = receive; 0 = hold receiver and go IDLE.
- rx_line  in  1  raw serial line, the same signal feeding the receiver.
- frame_in  in  10  receiver frame: [0] start, [8:1] data LSB-first, [9] stop.
- frame_done  in  1  receiver end-of-frame flag; level, may last ≥1 cycle.
- rx_hold  out  1  drives the receiver reset.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head byte when out_valid & out_ready.
- fifo_count  out  ADDR_W+1  current occupancy.
- frame_err  out  1  sticky framing error.
- overrun_err  out  1  sticky overrun (byte dropped).
- frame_err_cnt  out  CNT_W  saturating count of bad frames.
- drop_cnt  out  CNT_W  saturating count of dropped bytes.
- err_clear  in  1  synchronous clear of sticky flags and counters.

Behaviour:
- Reset values:
  - state = IDLE, rx_hold = 1, FIFO empty, out_valid = 0, out_data = 0, fifo_count = 0.
  - All error flags and counters = 0; frame_done edge register = 0.
- frame_done is edge-detected with a registered copy. Only a 0→1 transition starts capture, so a multi-cycle flag produces one capture.
- States:
  - IDLE: rx_hold = 1. Go to ARMED when enable = 1.
  - ARMED: rx_hold = 0. On a frame_done rising edge at edge E0, latch frame_in and go to CHECK.
  - CHECK (E1): if start = 0 and stop = 1, go to PUSH. Otherwise set frame_err, increment frame_err_cnt, clear the idle counter, and go to RECOVER.
  - PUSH (E2): write frame[8:1] to the FIFO, then go to ARMED.
  - RECOVER: rx_hold = 1. The idle counter increments while rx_line = 1 and resets to 0 when rx_line = 0. When the count reaches IDLE_SAMPLES, go to ARMED.
- Latency: a byte is visible on out_data with out_valid = 1 after edge E2 when the FIFO was empty, i.e. 2 cycles after the sampling edge.
- FIFO rules:
  - Push when full with no pop in the same cycle: the byte is dropped, overrun_err is set, drop_cnt increments.
  - Push and pop in the same cycle when full: both occur, no drop, count unchanged.
  - Push and pop when empty: the push occurs; the pop is ignored because out_valid = 0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - out_data is the registered head entry and holds its value while out_ready = 0.
- enable dropped in any state: go to IDLE on the next edge and abandon any frame in progress. FIFO contents are retained and continue to drain.
- Counters saturate at all-ones.
- err_clear clears flags and counters. If err_clear and a new error occur in the same cycle, the new error wins: flag = 1, counter = 1.
- A frame_done edge arriving during CHECK, PUSH, RECOVER or IDLE is ignored.
- Asynchronous rst mid-frame returns every register to its reset value immediately.

Decomposition:
- Package rx_ctrl_pkg holds:
  - State enum (IDLE, ARMED, CHECK, PUSH, RECOVER).
  - Frame bit-index constants START_BIT = 0, STOP_BIT = 9, DATA_LSB = 1.
  - Default FIFO_DEPTH.
- Sub-module rx_byte_fifo: synchronous FIFO with full, empty and count outputs. The controller FSM and error logic stay in the top module.

Test Plan:
- Good frame: frame_in = 10'b1_10100101_0, 1-cycle frame_done → out_data = 8'hA5, out_valid = 1 two cycles after the sampling edge, fifo_count = 1.
- Multi-cycle frame_done: hold frame_done high for 3 cycles with frame 8'h3C → exactly one push, fifo_count = 1.
- Bad stop: frame_in[9] = 0 → frame_err = 1, frame_err_cnt = 1, rx_hold = 1. Then 7 high rx_line samples, one low, 8 high → ARMED only after the 8th consecutive high sample.
- Overrun: out_ready = 0, push 5 good frames (8'h01..8'h05) → fifo_count = 4, overrun_err = 1, drop_cnt = 1, head = 8'h01. Drain yields 01, 02, 03, 04.
- Full with simultaneous pop: FIFO full, out_ready = 1 in the PUSH cycle → no drop, fifo_count stays 4.
- Control: err_clear in the same cycle as a CHECK failure → frame_err_cnt = 1. enable = 0 mid-frame → IDLE with rx_hold = 1 and FIFO preserved. Async rst → all outputs at reset values.
